decode: RTL

Instruction-decode stage of the MIPS pipeline. It sits directly downstream of `fetch`, consuming `ir` and `npc`, and sits upstream of execute.
- Holds the 32×32 register file, with write-back into it.
- Decodes the supported subset into control signals.
- Resolves `beq` and `j` in this stage, driving `pc_i`/`pc_s` back into `fetch`.
- Detects load-use hazards and requests a fetch hold.

---
 rtl/decode.sv | 77 +++++++
 1 files changed

// File: rtl/decode.sv
// decode: MIPS decode stage with register file, beq/j resolution and load-use stall
module decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic [31:0] npc,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] pc_i,
  output logic        pc_s,
  output logic        stall,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] imm,
  output logic [4:0]  dest,
  output logic [31:0] npc_o,
  output logic [31:0] ir_o,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic [2:0]  alu_op
);
  logic [31:0] rf [32];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_val, rt_val, sext;
  logic        is_r, r_ok, is_addi, is_lw, is_sw, is_beq, is_j, bubble;
  logic [2:0]  r_alu;
  assign op      = ir[31:26];
  assign funct   = ir[5:0];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign sext    = {{16{ir[15]}}, ir[15:0]};
  assign is_r    = op == 6'h00;
  assign is_addi = op == 6'h08;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2b;
  assign is_beq  = op == 6'h04;
  assign is_j    = op == 6'h02;
  assign r_ok    = is_r && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                            funct == 6'h25 || funct == 6'h2a);
  assign r_alu   = funct == 6'h22 ? 3'd1 : funct == 6'h24 ? 3'd2 :
                   funct == 6'h25 ? 3'd3 : funct == 6'h2a ? 3'd4 : 3'd0;
  // Write-through bypass so a same-cycle write-back is visible to this read
  assign rs_val  = rs == 5'd0 ? 32'd0 : (wb_we && wb_addr == rs) ? wb_data : rf[rs];
  assign rt_val  = rt == 5'd0 ? 32'd0 : (wb_we && wb_addr == rt) ? wb_data : rf[rt];
  assign stall   = mem_read && dest != 5'd0 &&
                   (dest == rs || (dest == rt && (is_r || is_beq || is_sw)));
  assign bubble  = stall || !(r_ok || is_addi || is_lw || is_sw || is_beq || is_j);
  assign pc_i    = is_beq ? npc + {sext[29:0], 2'b00} :
                   is_j   ? {npc[31:28], ir[25:0], 2'b00} : npc;
  assign pc_s    = !stall && ((is_beq && rs_val == rt_val) || is_j);
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      a <= '0; b <= '0; imm <= '0; dest <= '0; npc_o <= '0; ir_o <= '0;
      reg_write <= 1'b0; mem_read <= 1'b0; mem_write <= 1'b0; alu_src <= 1'b0;
      alu_op <= '0;
    end else begin
      if (wb_we && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
      a         <= rs_val;
      b         <= rt_val;
      imm       <= sext;
      npc_o     <= npc;
      ir_o      <= bubble ? 32'd0 : ir;
      dest      <= bubble ? 5'd0 : is_r ? rd : (is_addi || is_lw) ? rt : 5'd0;
      reg_write <= !bubble && (r_ok || is_addi || is_lw);
      mem_read  <= !bubble && is_lw;
      mem_write <= !bubble && is_sw;
      alu_src   <= !bubble && (is_addi || is_lw || is_sw);
      alu_op    <= (!bubble && r_ok) ? r_alu : 3'd0;
    end
  end
endmodule
